// File: rtl/gamma_pkg.sv
// gamma_pkg: shared constants and types for the gamma LUT loader.
// Bus bit positions, LUT depth and the loader state encoding.
package gamma_pkg;

    localparam int GB_W       = 22;
    localparam int GB_PRESENT = 21;
    localparam int GB_CLK     = 20;
    localparam int GB_EN      = 19;
    localparam int GB_WR      = 18;
    localparam int GB_ADDR_HI = 17;
    localparam int GB_ADDR_LO = 8;
    localparam int GB_DATA_HI = 7;
    localparam int GB_DATA_LO = 0;

    localparam int GAMMA_ENTRIES = 768;
    localparam int ADDR_W        = 10;
    localparam int DATA_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_LOAD = 2'd2
    } gamma_ld_state_t;

    function automatic logic addr_is_last(
        input logic [ADDR_W-1:0] a,
        input logic [ADDR_W-1:0] last
    );
        return a == last;
    endfunction

endpackage

// File: rtl/gamma_loader.sv
// gamma_loader: writes identity curve after reset, then streamed curves
// on command, onto the 22-bit gamma LUT bus with gated enable.
module gamma_loader
    import gamma_pkg::*;
#(
    parameter int ENTRIES = GAMMA_ENTRIES
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              load_start,
    input  logic              load_abort,
    input  logic              en_req,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              busy,
    output logic              done,
    output logic              curve_valid,
    output logic              present,
    inout  wire  [GB_W-1:0]   gamma_bus
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ENTRIES - 1);

    gamma_ld_state_t   state;
    gamma_ld_state_t   state_d;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_d;
    logic              cv_d;
    logic              done_d;
    logic              rdy_d;
    logic              busy_d;
    logic              en_d;
    logic              wr_d;
    logic [ADDR_W-1:0] waddr_d;
    logic [DATA_W-1:0] wdata_d;

    logic              bus_en;
    logic              bus_wr;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_data;

    logic              accept;

    assign accept = s_valid && s_ready && (state == ST_LOAD);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_FILL;
            addr        <= '0;
            curve_valid <= 1'b0;
            s_ready     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            present     <= 1'b0;
            bus_en      <= 1'b0;
            bus_wr      <= 1'b0;
            bus_addr    <= '0;
            bus_data    <= '0;
        end else begin
            state       <= state_d;
            addr        <= addr_d;
            curve_valid <= cv_d;
            s_ready     <= rdy_d;
            busy        <= busy_d;
            done        <= done_d;
            present     <= gamma_bus[GB_PRESENT];
            bus_en      <= en_d;
            bus_wr      <= wr_d;
            bus_addr    <= waddr_d;
            bus_data    <= wdata_d;
        end
    end

    always_comb begin
        state_d = state;
        addr_d  = addr;
        cv_d    = curve_valid;
        done_d  = 1'b0;
        wr_d    = 1'b0;
        waddr_d = bus_addr;
        wdata_d = bus_data;

        // restart wins over abort; a byte offered in that cycle is dropped
        if (load_start) begin
            state_d = ST_LOAD;
            addr_d  = '0;
            cv_d    = 1'b0;
        end else if (load_abort && state != ST_IDLE) begin
            state_d = ST_IDLE;
            addr_d  = '0;
            cv_d    = 1'b0;
        end else begin
            unique case (state)
                ST_FILL: begin
                    wr_d    = 1'b1;
                    waddr_d = addr;
                    wdata_d = addr[DATA_W-1:0];
                    if (addr_is_last(addr, LAST)) begin
                        state_d = ST_IDLE;
                        addr_d  = '0;
                        cv_d    = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        addr_d = addr + 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        wr_d    = 1'b1;
                        waddr_d = addr;
                        wdata_d = s_data;
                        if (addr_is_last(addr, LAST)) begin
                            state_d = ST_IDLE;
                            addr_d  = '0;
                            cv_d    = 1'b1;
                            done_d  = 1'b1;
                        end else begin
                            addr_d = addr + 1'b1;
                        end
                    end
                end
                ST_IDLE: begin
                end
                default: begin
                    state_d = ST_IDLE;
                    addr_d  = '0;
                    cv_d    = 1'b0;
                end
            endcase
        end

        rdy_d  = (state_d == ST_LOAD);
        busy_d = (state == ST_FILL) || (state == ST_LOAD);
        en_d   = en_req && curve_valid && !busy;
    end

    assign gamma_bus[GB_PRESENT]             = 1'bz;
    assign gamma_bus[GB_CLK]                 = clk_sys;
    assign gamma_bus[GB_EN]                  = bus_en;
    assign gamma_bus[GB_WR]                  = bus_wr;
    assign gamma_bus[GB_ADDR_HI:GB_ADDR_LO]  = bus_addr;
    assign gamma_bus[GB_DATA_HI:GB_DATA_LO]  = bus_data;

endmodule

// File: tb/tb_gamma_loader.sv
// tb_gamma_loader: directed bench for gamma_loader with a bus receiver
// model that logs strobes and mirrors the LUT contents.
module tb_gamma_loader;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        load_start = 1'b0;
    logic        load_abort = 1'b0;
    logic        en_req = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready;
    logic        busy;
    logic        done;
    logic        curve_valid;
    logic        present;
    wire  [21:0] gamma_bus;
    logic        rx_attached = 1'b1;

    int total = 0;
    int bad = 0;

    int         mon_cnt = 0;
    int         mon_err = 0;
    int         mon_mode = 0;
    logic [9:0] mon_a;
    logic [7:0] mon_d;
    logic [7:0] mon_e;
    logic [7:0] lut [0:767];

    assign gamma_bus[21] = rx_attached;

    gamma_loader #(.ENTRIES(768)) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .load_start  (load_start),
        .load_abort  (load_abort),
        .en_req      (en_req),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .busy        (busy),
        .done        (done),
        .curve_valid (curve_valid),
        .present     (present),
        .gamma_bus   (gamma_bus)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (gamma_bus[18] === 1'b1) begin
            mon_a = gamma_bus[17:8];
            mon_d = gamma_bus[7:0];
            mon_e = (mon_mode == 0) ? mon_cnt[7:0] : 8'(255 - mon_cnt);
            if (mon_a !== 10'(mon_cnt) || mon_d !== mon_e) mon_err++;
            if (mon_a < 10'd768) lut[mon_a] = mon_d;
            mon_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk_sys);
        #2;
    endtask

    task automatic mon_clear(input int mode);
        mon_mode = mode;
        mon_cnt  = 0;
        mon_err  = 0;
    endtask

    task automatic check_all_zero(input string tag);
        total++;
        if ({busy, s_ready, done, curve_valid, present} !== 5'b0) begin
            bad++;
            $display("FAIL %s_flags got=%b want=00000", tag,
                     {busy, s_ready, done, curve_valid, present});
        end
        total++;
        if (gamma_bus[19:0] !== 20'h0) begin
            bad++;
            $display("FAIL %s_bus got=%h want=00000", tag, gamma_bus[19:0]);
        end
    endtask

    // caller holds reset low; this releases it and checks the identity fill
    task automatic run_fill(input string tag);
        int done_cnt = 0;
        int done_cyc = -1;
        int lut_bad = 0;
        mon_clear(0);
        reset_n = 1'b1;
        for (int c = 1; c <= 800; c++) begin
            step;
            if (c == 1) begin
                total++;
                if (gamma_bus[18] !== 1'b1 || gamma_bus[17:8] !== 10'd0) begin
                    bad++;
                    $display("FAIL %s_first got wr=%b a=%0d want wr=1 a=0",
                             tag, gamma_bus[18], gamma_bus[17:8]);
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = c;
            end
        end
        total++;
        if (mon_cnt != 768) begin
            bad++;
            $display("FAIL %s_count got=%0d want=768", tag, mon_cnt);
        end
        total++;
        if (mon_err != 0) begin
            bad++;
            $display("FAIL %s_seq got=%0d bad strobes want=0", tag, mon_err);
        end
        total++;
        if (done_cnt != 1 || done_cyc != 768) begin
            bad++;
            $display("FAIL %s_done got n=%0d cyc=%0d want n=1 cyc=768",
                     tag, done_cnt, done_cyc);
        end
        for (int i = 0; i < 768; i++) begin
            if (lut[i] !== 8'(i)) lut_bad++;
        end
        total++;
        if (lut_bad != 0) begin
            bad++;
            $display("FAIL %s_lut got=%0d wrong entries want=0", tag, lut_bad);
        end
        total++;
        if (curve_valid !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_end got cv=%b busy=%b want cv=1 busy=0",
                     tag, curve_valid, busy);
        end
    endtask

    task automatic test_reset;
        step;
        step;
        step;
        check_all_zero("reset");
    endtask

    task automatic test_fill;
        run_fill("fill");
        total++;
        if (present !== 1'b1) begin
            bad++;
            $display("FAIL present_attached got=%b want=1", present);
        end
    endtask

    task automatic test_load_en;
        int idx = 0;
        int done_cnt = 0;
        int cv_bad = 0;
        int en_bad = 0;
        logic rdy_prev;
        en_req = 1'b1;
        step;
        step;
        total++;
        if (gamma_bus[19] !== 1'b1) begin
            bad++;
            $display("FAIL en_before got=%b want=1", gamma_bus[19]);
        end
        mon_clear(1);
        load_start = 1'b1;
        step;
        load_start = 1'b0;
        total++;
        if (s_ready !== 1'b1 || curve_valid !== 1'b0) begin
            bad++;
            $display("FAIL load_enter got rdy=%b cv=%b want rdy=1 cv=0",
                     s_ready, curve_valid);
        end
        for (int c = 0; c < 6000 && idx < 768; c++) begin
            rdy_prev = s_ready;
            s_valid  = ($urandom_range(0, 3) != 0);
            s_data   = 8'(255 - idx);
            step;
            if (s_valid && rdy_prev) idx++;
            if (done === 1'b1) done_cnt++;
            if (idx < 768) begin
                if (curve_valid !== 1'b0) cv_bad++;
                if (idx > 0 && gamma_bus[19] !== 1'b0) en_bad++;
            end
        end
        s_valid = 1'b0;
        total++;
        if (idx != 768) begin
            bad++;
            $display("FAIL load_timeout got=%0d bytes want=768", idx);
        end
        total++;
        if ({done, curve_valid, s_ready, busy} !== 4'b1101) begin
            bad++;
            $display("FAIL load_last got dn/cv/rdy/busy=%b want=1101",
                     {done, curve_valid, s_ready, busy});
        end
        step;
        total++;
        if ({busy, gamma_bus[19], done} !== 3'b000) begin
            bad++;
            $display("FAIL load_busyfall got busy/en/dn=%b want=000",
                     {busy, gamma_bus[19], done});
        end
        step;
        total++;
        if (gamma_bus[19] !== 1'b1) begin
            bad++;
            $display("FAIL en_after got=%b want=1", gamma_bus[19]);
        end
        total++;
        if (mon_cnt != 768 || mon_err != 0) begin
            bad++;
            $display("FAIL load_seq got n=%0d err=%0d want n=768 err=0",
                     mon_cnt, mon_err);
        end
        total++;
        if (done_cnt != 1 || cv_bad != 0 || en_bad != 0) begin
            bad++;
            $display("FAIL load_flags got dn=%0d cv=%0d en=%0d want 1 0 0",
                     done_cnt, cv_bad, en_bad);
        end
    endtask

    task automatic feed_continuous(input int n, output int got);
        logic rdy_prev;
        got = 0;
        for (int c = 0; c < 4 * n && got < n; c++) begin
            rdy_prev = s_ready;
            s_valid  = 1'b1;
            s_data   = 8'(255 - got);
            step;
            if (rdy_prev) got++;
        end
    endtask

    task automatic test_abort;
        int got;
        mon_clear(1);
        load_start = 1'b1;
        step;
        load_start = 1'b0;
        feed_continuous(300, got);
        load_abort = 1'b1;
        s_data     = 8'(255 - 300);
        step;
        load_abort = 1'b0;
        for (int i = 0; i < 5; i++) step;
        s_valid = 1'b0;
        total++;
        if (got != 300 || mon_cnt != 300 || mon_err != 0) begin
            bad++;
            $display("FAIL abort_count got fed=%0d n=%0d err=%0d want 300",
                     got, mon_cnt, mon_err);
        end
        total++;
        if ({curve_valid, gamma_bus[19], s_ready, busy} !== 4'b0000) begin
            bad++;
            $display("FAIL abort_flags got cv/en/rdy/busy=%b want=0000",
                     {curve_valid, gamma_bus[19], s_ready, busy});
        end
    endtask

    task automatic test_reset_mid;
        int got;
        mon_clear(1);
        load_start = 1'b1;
        step;
        load_start = 1'b0;
        feed_continuous(500, got);
        s_valid = 1'b0;
        @(negedge clk_sys);
        #1;
        total++;
        if (got != 500 || mon_cnt != 500 || mon_err != 0) begin
            bad++;
            $display("FAIL restart_seq got fed=%0d n=%0d err=%0d want 500",
                     got, mon_cnt, mon_err);
        end
        reset_n = 1'b0;
        #1;
        check_all_zero("rstmid");
        step;
        step;
        check_all_zero("rsthold");
        run_fill("refill");
    endtask

    task automatic test_absent;
        rx_attached = 1'b0;
        reset_n     = 1'b0;
        step;
        step;
        run_fill("absent");
        total++;
        if (present !== 1'b0) begin
            bad++;
            $display("FAIL present_absent got=%b want=0", present);
        end
    endtask

    initial begin
        test_reset;
        test_fill;
        test_load_en;
        test_abort;
        test_reset_mid;
        test_absent;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
